// File: rtl/adder_accumulate_ctrl_if.sv
// Operand/accumulate bus between the controller, its user-side driver and the
// external combinational adder.
interface adder_accumulate_ctrl_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REPS_W = 4
);
  logic [WIDTH-1:0]  sw;
  logic              load_b;
  logic              clear_a;
  logic              run;
  logic [REPS_W-1:0] reps;
  logic [WIDTH-1:0]  adder_a;
  logic [WIDTH-1:0]  adder_b;
  logic [WIDTH-1:0]  adder_sum;
  logic              adder_co;
  logic              co;
  logic              busy;
  logic              done;

  // Controller side
  modport slave (
    input  sw, load_b, clear_a, run, reps, adder_sum, adder_co,
    output adder_a, adder_b, co, busy, done
  );

  // Driver/adder side
  modport master (
    output sw, load_b, clear_a, run, reps, adder_sum, adder_co,
    input  adder_a, adder_b, co, busy, done
  );
endinterface

// File: rtl/adder_accumulate_ctrl.sv
// Accumulator controller around an external combinational adder: holds A/B,
// writes Sum back into A a programmable number of times per run.
module adder_accumulate_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REPS_W = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  adder_accumulate_ctrl_if.slave io_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [REPS_W-1:0] r_cnt;
  logic              r_co;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_state_nxt;
  logic [WIDTH-1:0]  w_a_nxt;
  logic [WIDTH-1:0]  w_b_nxt;
  logic [REPS_W-1:0] w_cnt_nxt;
  logic              w_co_nxt;

  // Next-state and datapath update; Run wins over LoadB/ClearA in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_co_nxt    = r_co;
    case (r_state)
      S_IDLE: begin
        if (io_bus.run) begin
          w_cnt_nxt   = io_bus.reps;
          w_co_nxt    = 1'b0;
          w_state_nxt = (io_bus.reps != '0) ? S_ADD : S_DONE;
        end else begin
          if (io_bus.load_b)  w_b_nxt = io_bus.sw;
          if (io_bus.clear_a) w_a_nxt = '0;
        end
      end
      S_ADD: begin
        w_a_nxt   = io_bus.adder_sum;
        w_co_nxt  = r_co | io_bus.adder_co;
        w_cnt_nxt = r_cnt - REPS_W'(1);
        if (r_cnt == REPS_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!io_bus.run) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Busy/Done are registered from the next state so they align with ADD/DONE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_co    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_co    <= w_co_nxt;
      r_busy  <= (w_state_nxt == S_ADD) || (w_state_nxt == S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign io_bus.adder_a = r_a;
  assign io_bus.adder_b = r_b;
  assign io_bus.co      = r_co;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// Directed + randomized bench for adder_accumulate_ctrl with an arithmetic
// reference model of A, B and the sticky carry.
module tb_adder_accumulate_ctrl;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned REPS_W = 4;
  localparam int unsigned MODV   = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst;

  adder_accumulate_ctrl_if #(.WIDTH(WIDTH), .REPS_W(REPS_W)) bus ();

  adder_accumulate_ctrl #(.WIDTH(WIDTH), .REPS_W(REPS_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  // Behavioural combinational adder
  assign {bus.adder_co, bus.adder_sum} =
    (WIDTH+1)'(bus.adder_a) + (WIDTH+1)'(bus.adder_b);

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned m_a;
  int unsigned m_b;
  bit          m_co;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit e_busy, input bit e_done);
    chk({tag, ".A"},    32'(bus.adder_a), m_a);
    chk({tag, ".B"},    32'(bus.adder_b), m_b);
    chk({tag, ".CO"},   32'(bus.co),      32'(m_co));
    chk({tag, ".Busy"}, 32'(bus.busy),    32'(e_busy));
    chk({tag, ".Done"}, 32'(bus.done),    32'(e_done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_b(input int unsigned v);
    bus.sw     = WIDTH'(v);
    bus.load_b = 1'b1;
    tick();
    bus.load_b = 1'b0;
    m_b = v % MODV;
    check_all("loadb", 1'b0, 1'b0);
  endtask

  task automatic clear_a();
    bus.clear_a = 1'b1;
    tick();
    bus.clear_a = 1'b0;
    m_a = 0;
    check_all("cleara", 1'b0, 1'b0);
  endtask

  // One full run: accept, n adds, DONE, HOLD (optionally with Run held), back to IDLE
  task automatic do_run(input int n, input int extra_hold, input bit poke);
    int unsigned sum;
    bus.run  = 1'b1;
    bus.reps = REPS_W'(n);
    if (poke) begin
      bus.sw      = 16'h1111;
      bus.load_b  = 1'b1;
      bus.clear_a = 1'b1;
    end
    tick();
    m_co = 1'b0;
    check_all("accept", 1'b1, n == 0);
    if (extra_hold == 0) bus.run = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      sum  = m_a + m_b;
      m_co = m_co | (sum >= MODV);
      m_a  = sum % MODV;
      check_all($sformatf("add%0d", k), 1'b1, k == n);
    end
    tick();
    check_all("hold", 1'b0, 1'b0);
    for (int h = 0; h < extra_hold; h++) begin
      tick();
      check_all("hold_run", 1'b0, 1'b0);
    end
    bus.run     = 1'b0;
    bus.load_b  = 1'b0;
    bus.clear_a = 1'b0;
    tick();
    check_all("idle", 1'b0, 1'b0);
  endtask

  initial begin
    bus.sw      = '0;
    bus.load_b  = 1'b0;
    bus.clear_a = 1'b0;
    bus.run     = 1'b0;
    bus.reps    = '0;
    m_a = 0; m_b = 0; m_co = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0);
    #4 rst = 1'b0;
    tick();
    check_all("post_reset", 1'b0, 1'b0);

    // Async reset mid-cycle from a non-zero state
    load_b(32'h1234);
    do_run(2, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    m_a = 0; m_b = 0; m_co = 1'b0;
    check_all("async_reset", 1'b0, 1'b0);
    #2 rst = 1'b0;
    tick();
    check_all("async_release", 1'b0, 1'b0);

    // Basic accumulate: 3,6,9,C
    clear_a();
    load_b(32'h0003);
    do_run(4, 0, 1'b0);
    chk("basic.final", 32'(bus.adder_a), 32'h000C);

    // Carry: 8000,0000,8000 with sticky CO, cleared by next accepted run
    clear_a();
    load_b(32'h8000);
    do_run(3, 0, 1'b0);
    chk("carry.co", 32'(bus.co), 32'h1);
    do_run(0, 0, 1'b0);
    chk("reps0.co_cleared", 32'(bus.co), 32'h0);

    // Run held for about 20 cycles: exactly one run
    clear_a();
    load_b(32'h0007);
    do_run(2, 16, 1'b0);
    do_run(1, 0, 1'b0);

    // LoadB/ClearA during the run (and in the accept cycle) are ignored
    clear_a();
    load_b(32'h0002);
    do_run(4, 0, 1'b1);

    // Abort: reset after the second of four adds
    clear_a();
    load_b(32'h0005);
    bus.run  = 1'b1;
    bus.reps = REPS_W'(4);
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    chk("abort.a_mid", 32'(bus.adder_a), 32'h000A);
    #2 rst = 1'b1;
    #1;
    m_a = 0; m_b = 0; m_co = 1'b0;
    check_all("abort_reset", 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all("post_abort", 1'b0, 1'b0);
    end

    // Randomized runs
    for (int i = 0; i < 10; i++) begin
      if ($urandom % 2 == 0) clear_a();
      load_b($urandom % MODV);
      do_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end
endmodule
